// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory bus arbiter: bus command
// encodings, FSM state enum and bus-owner enum.
package mem_arbiter_pkg;

  // Bus command encodings shared by the pipeline, arbiter and memory.
  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  // Per-transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // Which requester currently owns (or last owned) the bus.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and IDLE/BUSY/RESP sequencer sharing one
// variable-latency memory bus between instruction fetch and data access.
// Bus outputs and completion pulses are driven from registers; only the
// stall signals are combinational so the pipeline advances at the end of
// the response cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_vld,
  input  logic [31:0] if_req_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  input  logic [1:0]  dm_cmd,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_din,
  output logic [31:0] dm_dout,
  output logic        dm_done,
  output logic [1:0]  bus_cmd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_din,
  input  logic [31:0] bus_dout,
  input  logic        bus_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  owner_e        last_grant_q, last_grant_d;
  owner_e        owner_q, owner_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [1:0]    bus_cmd_q, bus_cmd_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic [31:0]   if_inst_q, if_inst_d;
  logic [31:0]   dm_dout_q, dm_dout_d;
  logic          err_q, err_d;
  logic          dm_pend_s;
  logic          grant_dm_s;
  logic [31:0]   result_s;
  logic          timeout_s;

  assign dm_pend_s = (dm_cmd != BUS_NONE);

  // State register and all registered bus/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_IF;
      owner_q      <= OWN_IF;
      cmd_q        <= BUS_NONE;
      bus_cmd_q    <= BUS_NONE;
      addr_q       <= 32'h0000_0000;
      din_q        <= 32'h0000_0000;
      cnt_q        <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      if_inst_q    <= 32'h0000_0000;
      dm_dout_q    <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
      bus_cmd_q    <= bus_cmd_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      cnt_q        <= cnt_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      if_inst_q    <= if_inst_d;
      dm_dout_q    <= dm_dout_d;
      err_q        <= err_d;
    end
  end

  // Grant, next-state, wait counter and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    bus_cmd_d    = bus_cmd_q;
    addr_d       = addr_q;
    din_d        = din_q;
    cnt_d        = cnt_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    if_inst_d    = 32'h0000_0000;
    dm_dout_d    = 32'h0000_0000;
    err_d        = 1'b0;
    // Data wins when alone, or on a tie when IF had the previous grant.
    grant_dm_s   = dm_pend_s && (!if_req_vld || (last_grant_q == OWN_IF));
    timeout_s    = (cnt_q == CNT_LAST) && !bus_ack;
    // Store completions and timeouts return zero.
    if (bus_ack && (cmd_q != BUS_STORE)) begin
      result_s = bus_dout;
    end else begin
      result_s = 32'h0000_0000;
    end

    case (state_q)
      IDLE: begin
        if (if_req_vld || dm_pend_s) begin
          if (grant_dm_s) begin
            owner_d = OWN_DM;
            cmd_d   = dm_cmd;
            addr_d  = dm_addr;
            din_d   = dm_din;
          end else begin
            owner_d = OWN_IF;
            cmd_d   = BUS_LOAD;
            addr_d  = if_req_addr;
            din_d   = 32'h0000_0000;
          end
          last_grant_d = owner_d;
          bus_cmd_d    = cmd_d;
          cnt_d        = '0;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus_ack || timeout_s) begin
          state_d   = RESP;
          bus_cmd_d = BUS_NONE;
          err_d     = timeout_s;
          if (owner_q == OWN_DM) begin
            dm_done_d = 1'b1;
            dm_dout_d = result_s;
          end else begin
            if_done_d = 1'b1;
            if_inst_d = result_s;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bus_cmd_d = BUS_NONE;
      end
    endcase
  end

  assign bus_cmd   = bus_cmd_q;
  assign bus_addr  = addr_q;
  assign bus_din   = din_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_inst   = if_inst_q;
  assign dm_dout   = dm_dout_q;
  assign err       = err_q;
  assign stall_if  = if_req_vld & ~if_done_q;
  assign stall_mem = dm_pend_s & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector tables with
// hand-computed expectations plus reset sequences.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req_vld;
  logic [31:0] if_req_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic [1:0]  dm_cmd;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_done;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr;
  logic [31:0] bus_din;
  logic [31:0] bus_dout;
  logic        bus_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic [1:0]  dc;
    logic [31:0] da;
    logic [31:0] dd;
    logic        ack;
    logic [31:0] bd;
    logic [1:0]  ecmd;
    logic [31:0] eaddr;
    logic [31:0] edin;
    logic        eifd;
    logic [31:0] einst;
    logic        edmd;
    logic [31:0] edout;
    logic        eerr;
    logic        esif;
    logic        esm;
  } vec_t;

  vec_t tab_a[11];
  vec_t tab_tie[8];
  vec_t tab_to[14];

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_vld(if_req_vld), .if_req_addr(if_req_addr),
    .if_inst(if_inst), .if_done(if_done),
    .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_dout(dm_dout), .dm_done(dm_done),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_ack(bus_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic vec_t mk(
    input logic ifv, input logic [31:0] ifa, input logic [1:0] dc,
    input logic [31:0] da, input logic [31:0] dd, input logic ack,
    input logic [31:0] bd, input logic [1:0] ecmd, input logic [31:0] eaddr,
    input logic [31:0] edin, input logic eifd, input logic [31:0] einst,
    input logic edmd, input logic [31:0] edout, input logic eerr,
    input logic esif, input logic esm);
    vec_t v;
    v.ifv = ifv; v.ifa = ifa; v.dc = dc; v.da = da; v.dd = dd;
    v.ack = ack; v.bd = bd; v.ecmd = ecmd; v.eaddr = eaddr; v.edin = edin;
    v.eifd = eifd; v.einst = einst; v.edmd = edmd; v.edout = edout;
    v.eerr = eerr; v.esif = esif; v.esm = esm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    if_req_vld = 1'b0; if_req_addr = 32'h0; dm_cmd = BUS_NONE;
    dm_addr = 32'h0; dm_din = 32'h0; bus_ack = 1'b0; bus_dout = 32'h0;
  endtask

  // Drive one cycle of inputs just after the rising edge, check at the falling edge.
  task automatic run_vec(input vec_t v, input string nm);
    @(posedge clk); #1;
    if_req_vld = v.ifv; if_req_addr = v.ifa; dm_cmd = v.dc;
    dm_addr = v.da; dm_din = v.dd; bus_ack = v.ack; bus_dout = v.bd;
    @(negedge clk);
    chk({nm, ".bus_cmd"},   32'(bus_cmd),   32'(v.ecmd));
    chk({nm, ".bus_addr"},  bus_addr,       v.eaddr);
    chk({nm, ".bus_din"},   bus_din,        v.edin);
    chk({nm, ".if_done"},   32'(if_done),   32'(v.eifd));
    chk({nm, ".if_inst"},   if_inst,        v.einst);
    chk({nm, ".dm_done"},   32'(dm_done),   32'(v.edmd));
    chk({nm, ".dm_dout"},   dm_dout,        v.edout);
    chk({nm, ".err"},       32'(err),       32'(v.eerr));
    chk({nm, ".stall_if"},  32'(stall_if),  32'(v.esif));
    chk({nm, ".stall_mem"}, 32'(stall_mem), 32'(v.esm));
  endtask

  // Assert reset asynchronously, check outputs before any edge, release after a cycle.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    if_req_vld = 1'b1; dm_cmd = BUS_STORE;
    #1;
    chk({nm, ".bus_cmd"},   32'(bus_cmd), 32'(BUS_NONE));
    chk({nm, ".bus_addr"},  bus_addr, 32'h0);
    chk({nm, ".bus_din"},   bus_din, 32'h0);
    chk({nm, ".if_done"},   32'(if_done), 32'h0);
    chk({nm, ".dm_done"},   32'(dm_done), 32'h0);
    chk({nm, ".if_inst"},   if_inst, 32'h0);
    chk({nm, ".dm_dout"},   dm_dout, 32'h0);
    chk({nm, ".err"},       32'(err), 32'h0);
    chk({nm, ".stall_if"},  32'(stall_if), 32'h1);
    chk({nm, ".stall_mem"}, 32'(stall_mem), 32'h1);
    @(posedge clk);
    @(negedge clk);
    zero_inputs();
    rst = 1'b0;
  endtask

  localparam logic [1:0] N = BUS_NONE;
  localparam logic [1:0] L = BUS_LOAD;
  localparam logic [1:0] S = BUS_STORE;

  initial begin
    // IF-only fetch, then store with three BUSY cycles and acks in RESP/IDLE.
    tab_a[0]  = mk(1, 32'h40, N, 0, 0, 0, 0,            N, 32'h0,   0, 0, 0, 0, 0, 0, 1, 0);
    tab_a[1]  = mk(1, 32'h40, N, 0, 0, 1, 32'h13,       L, 32'h40,  0, 0, 0, 0, 0, 0, 1, 0);
    tab_a[2]  = mk(1, 32'h40, N, 0, 0, 0, 0,            N, 32'h40,  0, 1, 32'h13, 0, 0, 0, 0, 0);
    tab_a[3]  = mk(0, 0, N, 0, 0, 0, 0,                 N, 32'h40,  0, 0, 0, 0, 0, 0, 0, 0);
    tab_a[4]  = mk(0, 0, S, 32'h100, 32'hDEADBEEF, 0, 0, N, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_a[5]  = mk(0, 0, S, 32'h100, 32'hDEADBEEF, 0, 0, S, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1);
    tab_a[6]  = mk(0, 0, S, 32'h100, 32'hDEADBEEF, 0, 0, S, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1);
    tab_a[7]  = mk(0, 0, S, 32'h100, 32'hDEADBEEF, 1, 32'h12345678, S, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1);
    tab_a[8]  = mk(0, 0, S, 32'h100, 32'hDEADBEEF, 1, 32'hAAAA5555, N, 32'h100, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0);
    tab_a[9]  = mk(0, 0, N, 0, 0, 1, 32'hAAAA5555,      N, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    tab_a[10] = mk(0, 0, N, 0, 0, 0, 0,                 N, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);

    // Both requesters held after reset: data, then IF, then data again.
    tab_tie[0] = mk(1, 32'h200, L, 32'h300, 32'h55, 0, 0,      N, 32'h0,   0,      0, 0, 0, 0, 0, 1, 1);
    tab_tie[1] = mk(1, 32'h200, L, 32'h300, 32'h55, 1, 32'hD1, L, 32'h300, 32'h55, 0, 0, 0, 0, 0, 1, 1);
    tab_tie[2] = mk(1, 32'h200, L, 32'h300, 32'h55, 0, 0,      N, 32'h300, 32'h55, 0, 0, 1, 32'hD1, 0, 1, 0);
    tab_tie[3] = mk(1, 32'h200, L, 32'h300, 32'h55, 0, 0,      N, 32'h300, 32'h55, 0, 0, 0, 0, 0, 1, 1);
    tab_tie[4] = mk(1, 32'h200, L, 32'h300, 32'h55, 1, 32'h1F, L, 32'h200, 0,      0, 0, 0, 0, 0, 1, 1);
    tab_tie[5] = mk(1, 32'h200, L, 32'h300, 32'h55, 0, 0,      N, 32'h200, 0,      1, 32'h1F, 0, 0, 0, 0, 1);
    tab_tie[6] = mk(1, 32'h200, L, 32'h300, 32'h55, 0, 0,      N, 32'h200, 0,      0, 0, 0, 0, 0, 1, 1);
    tab_tie[7] = mk(1, 32'h200, L, 32'h300, 32'h55, 0, 0,      L, 32'h300, 32'h55, 0, 0, 0, 0, 0, 1, 1);

    // Load timeout with TIMEOUT=4, then the same load acked in the 4th BUSY cycle.
    tab_to[0]  = mk(0, 0, L, 32'h400, 0, 0, 32'h99, N, 32'h40,  0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[1]  = mk(0, 0, L, 32'h400, 0, 0, 32'h99, L, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[2]  = mk(0, 0, L, 32'h400, 0, 0, 32'h99, L, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[3]  = mk(0, 0, L, 32'h400, 0, 0, 32'h99, L, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[4]  = mk(0, 0, L, 32'h400, 0, 0, 32'h99, L, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[5]  = mk(0, 0, L, 32'h400, 0, 0, 32'h99, N, 32'h400, 0, 0, 0, 1, 0, 1, 0, 0);
    tab_to[6]  = mk(0, 0, N, 0, 0, 0, 0,            N, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
    tab_to[7]  = mk(0, 0, L, 32'h404, 0, 0, 0,      N, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[8]  = mk(0, 0, L, 32'h404, 0, 0, 0,      L, 32'h404, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[9]  = mk(0, 0, L, 32'h404, 0, 0, 0,      L, 32'h404, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[10] = mk(0, 0, L, 32'h404, 0, 0, 0,      L, 32'h404, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[11] = mk(0, 0, L, 32'h404, 0, 1, 32'h77, L, 32'h404, 0, 0, 0, 0, 0, 0, 0, 1);
    tab_to[12] = mk(0, 0, L, 32'h404, 0, 0, 0,      N, 32'h404, 0, 0, 0, 1, 32'h77, 0, 0, 0);
    tab_to[13] = mk(0, 0, N, 0, 0, 0, 0,            N, 32'h404, 0, 0, 0, 0, 0, 0, 0, 0);

    zero_inputs();
    do_reset("rst0");
    for (int i = 0; i < 11; i++) run_vec(tab_a[i], $sformatf("basic[%0d]", i));

    do_reset("rst1");
    for (int i = 0; i < 8; i++) run_vec(tab_tie[i], $sformatf("tie[%0d]", i));

    // Asynchronous reset in the middle of the data BUSY cycle above.
    #1;
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) run_vec(tab_a[i], $sformatf("after_rst[%0d]", i));

    for (int i = 0; i < 7; i++) run_vec(tab_to[i], $sformatf("timeout[%0d]", i));
    chk("timeout.state_idle", 32'(dut.state_q), 32'(IDLE));
    for (int i = 7; i < 14; i++) run_vec(tab_to[i], $sformatf("ack_last[%0d]", i));
    chk("ack_last.state_idle", 32'(dut.state_q), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
